// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational execute ALU between two
// requesters. Accepts one op per cycle, registers result/zero flag and hands
// it back to the owning requester over a valid/ready response channel.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins ties;
// default is round-robin on ties).
module alu_share_arbiter #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4,
  parameter int OPC_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [XLEN-1:0]   req0_a,
  input  logic [XLEN-1:0]   req1_a,
  input  logic [XLEN-1:0]   req0_b,
  input  logic [XLEN-1:0]   req1_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [OPC_W-1:0]  req0_opc,
  input  logic [OPC_W-1:0]  req1_opc,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [OPC_W-1:0]  alu_opc,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic       owner;
  logic       last_grant;
  logic       can_issue;
  logic [1:0] grant;
  logic       grant_sel;
  logic       handshake;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Grant, next state, ALU drive and response valid
  always_comb begin
    grant     = '0;
    grant_sel = 1'b0;
    state_nxt = state;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = '1;
    alu_opc   = '0;

    // A new op may issue when the response slot is empty or being drained
    // this cycle; never during reset.
    can_issue = !rst && ((state == S_IDLE) || rsp_ready[owner]);

    if (can_issue) begin
      unique case (req_valid)
        2'b01: grant = 2'b01;
        2'b10: begin grant = 2'b10; grant_sel = 1'b1; end
        2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          grant = 2'b01;
`else
          if (last_grant) begin
            grant = 2'b01;
          end else begin
            grant     = 2'b10;
            grant_sel = 1'b1;
          end
`endif
        end
        default: grant = '0;
      endcase
    end

    handshake = |grant;
    req_ready = grant;

    if (handshake) begin
      if (grant_sel) begin
        alu_a    = req1_a;
        alu_b    = req1_b;
        alu_ctrl = req1_ctrl;
        alu_opc  = req1_opc;
      end else begin
        alu_a    = req0_a;
        alu_b    = req0_b;
        alu_ctrl = req0_ctrl;
        alu_opc  = req0_opc;
      end
      state_nxt = S_RESP;
    end else if ((state == S_RESP) && rsp_ready[owner]) begin
      state_nxt = S_IDLE;
    end

    rsp_valid = (state == S_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end

  // Response capture and arbitration history
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else if (handshake) begin
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      owner      <= grant_sel;
      last_grant <= grant_sel;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter. A behavioural ALU closes the
// loop; expected responses are computed from the requester fields at
// handshake time, queued, and compared when the response is consumed.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req0_a, req1_a, req0_b, req1_b;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [6:0]  req0_opc, req1_opc;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [3:0]  alu_ctrl;
  logic [6:0]  alu_opc;
  logic        alu_zero, rsp_zero;

  typedef struct packed {
    logic        owner;
    logic [31:0] res;
    logic        zero;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return 32'($signed(a) >>> b[4:0]);
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      4'd10:   return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
  assign alu_zero   = (alu_result == 32'd0);

  alu_share_arbiter #(.XLEN(32), .CTRL_W(4), .OPC_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_ctrl(req0_ctrl), .req1_ctrl(req1_ctrl),
    .req0_opc(req0_opc), .req1_opc(req1_opc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_opc(alu_opc),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record every handshake seen at the sample point into the scoreboard.
  task automatic push_hs();
    logic [31:0] r;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        r = (i == 1) ? alu_fn(req1_a, req1_b, req1_ctrl) : alu_fn(req0_a, req0_b, req0_ctrl);
        q.push_back('{owner: 1'(i), res: r, zero: (r == 32'd0)});
      end
    end
  endtask

  task automatic sb_pop(output exp_t e, output bit ok);
    ok = (q.size() != 0);
    e  = ok ? q.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b00) begin
      n_err++; $display("FAIL reset_req_ready got=%b exp=00", req_ready);
    end
    step();
    rst = 1'b0; req_valid = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_result, rsp_zero} !== 35'd0) begin
      n_err++; $display("FAIL reset_rsp got=%b/%h/%b exp=00/0/0", rsp_valid, rsp_result, rsp_zero);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl, alu_opc} !== {64'd0, 4'hF, 7'd0}) begin
      n_err++; $display("FAIL idle_alu_drive got=%h/%h/%h/%h exp=0/0/f/0", alu_a, alu_b, alu_ctrl, alu_opc);
    end
    step();
  endtask

  task automatic test_single_op();
    exp_t e; bit ok;
    req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = 4'b0000; req0_opc = 7'b0110011;
    req1_a = 32'hDEAD; req1_b = 32'hBEEF; req1_ctrl = 4'd3; req1_opc = 7'b0010011;
    req_valid = 2'b01; rsp_ready = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL single_req_ready got=%b exp=01", req_ready);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl, alu_opc} !== {32'd5, 32'd7, 4'b0000, 7'b0110011}) begin
      n_err++; $display("FAIL single_alu_drive got=%h/%h/%h/%h", alu_a, alu_b, alu_ctrl, alu_opc);
    end
    push_hs();
    step();
    req_valid = 2'b00;
    @(negedge clk);
    sb_pop(e, ok);
    n_cmp++;
    if (!ok || rsp_valid !== 2'b01 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 ||
        {rsp_result, rsp_zero} !== {e.res, e.zero}) begin
      n_err++; $display("FAIL single_rsp got=%b/%0d/%b exp=01/12/0", rsp_valid, rsp_result, rsp_zero);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b00) begin
      n_err++; $display("FAIL single_rsp_clear got=%b exp=00", rsp_valid);
    end
    step();
  endtask

  task automatic test_branch_zero();
    exp_t e; bit ok;
    req1_a = 32'd9; req1_b = 32'd9; req1_ctrl = 4'b0001; req1_opc = 7'b1100011;
    req_valid = 2'b10; rsp_ready = 2'b10;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b10 || alu_opc !== 7'b1100011) begin
      n_err++; $display("FAIL branch_grant got=%b/%b exp=10/1100011", req_ready, alu_opc);
    end
    push_hs();
    step();
    req_valid = 2'b00;
    @(negedge clk);
    sb_pop(e, ok);
    n_cmp++;
    if (!ok || rsp_valid !== 2'b10 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 ||
        e.owner !== 1'b1 || e.zero !== 1'b1) begin
      n_err++; $display("FAIL branch_rsp got=%b/%0d/%b exp=10/0/1", rsp_valid, rsp_result, rsp_zero);
    end
    step();
  endtask

  task automatic test_tie();
    exp_t e; bit ok; logic g;
    req0_a = 32'd100; req0_b = 32'd3; req0_ctrl = 4'd0; req0_opc = 7'b0110011;
    req1_a = 32'd50;  req1_b = 32'd8; req1_ctrl = 4'd1; req1_opc = 7'b0010011;
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k > 0) begin
        sb_pop(e, ok);
        n_cmp++;
        if (!ok || rsp_valid !== (e.owner ? 2'b10 : 2'b01) || {rsp_result, rsp_zero} !== {e.res, e.zero}) begin
          n_err++; $display("FAIL tie_rsp%0d got=%b/%0d exp_owner=%b/%0d", k, rsp_valid, rsp_result, e.owner, e.res);
        end
      end
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 1'b0;
`else
      g = 1'(k % 2);
`endif
      n_cmp++;
      if (req_ready !== (g ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL tie_grant%0d got=%b exp_req=%0d", k, req_ready, g);
      end
      push_hs();
      step();
    end
    req_valid = 2'b00;
    @(negedge clk);
    sb_pop(e, ok);
    n_cmp++;
    if (!ok || rsp_valid !== (e.owner ? 2'b10 : 2'b01) || {rsp_result, rsp_zero} !== {e.res, e.zero}) begin
      n_err++; $display("FAIL tie_drain got=%b/%0d exp=%0d", rsp_valid, rsp_result, e.res);
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t e; bit ok;
    logic [31:0] held;
    req0_a = 32'd7; req0_b = 32'd3; req0_ctrl = 4'd4; req0_opc = 7'b0110011;
    req_valid = 2'b01; rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL bp_first_grant got=%b exp=01", req_ready);
    end
    push_hs();
    step();
    req1_a = 32'h8000_0000; req1_b = 32'd1; req1_ctrl = 4'd8; req1_opc = 7'b0110011;
    req_valid = 2'b10;
    held = 32'd4;
    for (int k = 0; k < 4; k++) begin
      rsp_ready = (k == 3) ? 2'b10 : 2'b00;
      @(negedge clk);
      n_cmp++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b01 || rsp_result !== held || rsp_zero !== 1'b0) begin
        n_err++; $display("FAIL bp_hold%0d got=%b/%b/%0d exp=00/01/%0d", k, req_ready, rsp_valid, rsp_result, held);
      end
      step();
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 2'b10) begin
      n_err++; $display("FAIL bp_release_grant got=%b exp=10", req_ready);
    end
    sb_pop(e, ok);
    n_cmp++;
    if (!ok || rsp_valid !== 2'b01 || {rsp_result, rsp_zero} !== {e.res, e.zero}) begin
      n_err++; $display("FAIL bp_rsp0 got=%b/%0d exp=01/%0d", rsp_valid, rsp_result, e.res);
    end
    push_hs();
    step();
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    sb_pop(e, ok);
    n_cmp++;
    if (!ok || rsp_valid !== 2'b10 || rsp_result !== 32'd1 || {rsp_result, rsp_zero} !== {e.res, e.zero}) begin
      n_err++; $display("FAIL bp_rsp1 got=%b/%0d exp=10/1", rsp_valid, rsp_result);
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd1 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL idle_hold got=%b/%0d/%b exp=00/1/0", rsp_valid, rsp_result, rsp_zero);
    end
    step();
  endtask

  task automatic test_reset_midop();
    exp_t e; bit ok;
    req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = 4'd0;
    req_valid = 2'b01; rsp_ready = 2'b00;
    @(negedge clk);
    push_hs();
    step();
    req_valid = 2'b11; rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b01 || req_ready !== 2'b00) begin
      n_err++; $display("FAIL rst_mid_pending got=%b/%b exp=01/00", rsp_valid, req_ready);
    end
    q.delete();
    step();
    rst = 1'b0; rsp_ready = 2'b11;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 2'b00 || rsp_result !== 32'd0 || rsp_zero !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_clear got=%b/%0d/%b exp=00/0/0", rsp_valid, rsp_result, rsp_zero);
    end
    n_cmp++;
    if (req_ready !== 2'b01) begin
      n_err++; $display("FAIL rst_mid_first_tie got=%b exp=01", req_ready);
    end
    push_hs();
    step();
    req_valid = 2'b00;
    @(negedge clk);
    sb_pop(e, ok);
    n_cmp++;
    if (!ok || rsp_valid !== (e.owner ? 2'b10 : 2'b01) || {rsp_result, rsp_zero} !== {e.res, e.zero}) begin
      n_err++; $display("FAIL rst_mid_rsp got=%b/%0d exp=%0d", rsp_valid, rsp_result, e.res);
    end
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req0_a = '0; req1_a = '0; req0_b = '0; req1_b = '0;
    req0_ctrl = '0; req1_ctrl = '0; req0_opc = '0; req1_opc = '0;
    step();
    test_reset();
    test_single_op();
    test_branch_zero();
    test_tie();
    test_backpressure();
    test_reset_midop();
    n_cmp++;
    if (q.size() != 0) begin
      n_err++; $display("FAIL sb_leftover got=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
